tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing one UART tx among NUM_REQ requesters. Latches winner's byte,

---
 rtl/tx_arbiter.sv | 107 ++++++++++
 tb/tb_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   i_req      - per-requester send request (level, held until ack)
//   i_req_din  - per-requester byte, requester i on bits [8*i+7:8*i]
//   o_ack      - one-cycle pulse: owner's byte accepted by the transmitter
//   o_grant    - one-hot current owner, zero when idle
//   o_tx_send  - to transmitter send input
//   o_tx_din   - to transmitter data input
//   i_tx_busy  - from transmitter busy output
//   o_busy     - high whenever the arbiter is not idle
//   o_err      - one-cycle pulse when the transmitter never went busy
module tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [8*NUM_REQ-1:0]   i_req_din,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_tx_send,
    output logic [7:0]             o_tx_din,
    input  logic                   i_tx_busy,
    output logic                   o_busy,
    output logic                   o_err
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = BUSY_TIMEOUT > 1 ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, DONE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_own;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_next;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction

    // Scan from the far end back toward r_ptr so the closest requester wins.
    always_comb begin
        w_win = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (i_req[wrap(int'(r_ptr) + j)]) w_win = wrap(int'(r_ptr) + j);
        w_next = wrap(int'(r_own) + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_own     <= '0;
            r_cnt     <= '0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_tx_send <= 1'b0;
            o_tx_din  <= '0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_ack <= '0;
            o_err <= 1'b0;
            case (r_state)
                IDLE: if (|i_req) begin
                    r_state   <= LAUNCH;
                    r_own     <= w_win;
                    r_cnt     <= '0;
                    o_grant   <= NUM_REQ'(1) << w_win;
                    o_tx_din  <= i_req_din[{w_win, 3'b000} +: 8];
                    o_tx_send <= 1'b1;
                    o_busy    <= 1'b1;
                end
                LAUNCH: if (i_tx_busy) begin
                    r_state   <= DONE;
                    r_cnt     <= '0;
                    o_tx_send <= 1'b0;
                    o_ack     <= o_grant;
                end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never answered: abandon the byte, move past this owner.
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_ptr     <= w_next;
                    o_tx_send <= 1'b0;
                    o_grant   <= '0;
                    o_busy    <= 1'b0;
                    o_err     <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                DONE: if (!i_tx_busy) begin
                    r_state <= IDLE;
                    r_ptr   <= w_next;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: self-checking bench for tx_arbiter with a transaction-level reference model.
module tb_tx_arbiter;
    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int FRAME = 30;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_din;
    logic [N-1:0]   o_ack, o_grant;
    logic           o_tx_send, o_busy, o_err;
    logic [7:0]     o_tx_din;
    logic           tx_busy = 1'b0;

    tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_req_din(req_din),
        .o_ack(o_ack), .o_grant(o_grant), .o_tx_send(o_tx_send), .o_tx_din(o_tx_din),
        .i_tx_busy(tx_busy), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    bit tx_en, drop, rnd;
    int tcnt = 0;
    logic [7:0] rx_log [0:255];
    int rx_n = 0;
    int gr_log [0:255];
    int gr_n = 0, ack_cnt = 0, err_cnt = 0;
    int wait_n [N];
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int last_rx();
        return rx_n > 0 ? int'(rx_log[(rx_n - 1) % 256]) : -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: accepts a byte one clock after send, then stays busy for a frame.
    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tcnt    <= 0;
        end else if (tcnt == 0) begin
            if (tx_en && o_tx_send && !tx_busy) tcnt <= 1;
        end else begin
            if (tcnt == 1) begin
                tx_busy          <= 1'b1;
                rx_log[rx_n % 256] <= o_tx_din;
                rx_n             <= rx_n + 1;
            end
            if (tcnt == FRAME) begin
                tx_busy <= 1'b0;
                tcnt    <= 0;
            end else begin
                tcnt <= tcnt + 1;
            end
        end
    end

    // Reference model: owner index (-1 when idle), whether the byte was taken, wait clock count.
    int  m_own = -1, m_ptr = 0, m_cnt = 0;
    bit  m_taken = 0, chk_on = 0;
    logic [N-1:0] e_ack = '0, e_grant = '0;
    logic [7:0]   e_din = '0;
    logic         e_send = 0, e_err = 0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++)
            if (r[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        e_ack = '0;
        e_err = 1'b0;
        if (rst) begin
            chk_on = 1; m_own = -1; m_ptr = 0; m_cnt = 0;
            e_grant = '0; e_din = '0; e_send = 0;
        end else if (m_own < 0) begin
            if (pick(req, m_ptr) >= 0) begin
                m_own = pick(req, m_ptr); m_taken = 0; m_cnt = 0;
                e_grant = N'(1) << m_own; e_din = req_din[8*m_own +: 8]; e_send = 1;
            end
        end else if (!m_taken) begin
            if (tx_busy) begin
                m_taken = 1; e_send = 0; e_ack = e_grant;
            end else if (m_cnt == TO - 1) begin
                e_send = 0; e_err = 1; e_grant = '0;
                m_ptr = (m_own + 1) % N; m_own = -1;
            end else m_cnt++;
        end else if (!tx_busy) begin
            e_grant = '0; m_ptr = (m_own + 1) % N; m_own = -1;
        end
    end

    // Per-cycle compare, event logging and requester behaviour.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack",   32'(o_ack),     32'(e_ack));
            chk("grant", 32'(o_grant),   32'(e_grant));
            chk("send",  32'(o_tx_send), 32'(e_send));
            chk("din",   32'(o_tx_din),  32'(e_din));
            chk("busy",  32'(o_busy),    32'(m_own >= 0));
            chk("err",   32'(o_err),     32'(e_err));
        end
        if (o_ack != 0) begin
            ack_cnt++;
            chk("ack_byte", 32'(o_tx_din), 32'(last_rx()));
        end
        if (o_err) err_cnt++;
        if (o_grant != 0 && prev_grant == 0) begin
            int w = 0;
            for (int i = 0; i < N; i++) if (o_grant[i]) w = i;
            gr_log[gr_n % 256] = w;
            gr_n++;
            for (int i = 0; i < N; i++) begin
                if (i == w || !req[i]) wait_n[i] = 0;
                else begin
                    wait_n[i]++;
                    if (rnd) chk("starve", 32'(wait_n[i] < N), 32'd1);
                end
            end
        end
        prev_grant = o_grant;
        if (drop) req = req & ~o_ack;
        if (rnd)
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req_din[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1;
        step(); step(); rst = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int b = budget;
        while (ack_cnt < n && b > 0) begin step(); b--; end
        if (ack_cnt < n) chk("ack_timeout", 32'(ack_cnt), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int b = budget;
        while ((o_busy || req != 0) && b > 0) begin step(); b--; end
        if (o_busy) chk("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    int a0, g0, e0, t0, b;

    initial begin
        for (int i = 0; i < N; i++) wait_n[i] = 0;
        rst = 1'b1; req = '0; req_din = '0; tx_en = 1; drop = 1; rnd = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_din",   32'(o_tx_din), 32'd0);

        // single request, one-cycle latency
        req_din[7:0] = 8'h5A; req = 4'b0001; a0 = ack_cnt;
        @(posedge clk); #1;
        chk("t1_send",  32'(o_tx_send), 32'd1);
        chk("t1_grant", 32'(o_grant),   32'd1);
        wait_acks(a0 + 1, 200); wait_idle(200);
        chk("t1_rx",   32'(last_rx()), 32'h5A);
        chk("t1_acks", 32'(ack_cnt - a0), 32'd1);

        // all four, in pointer order
        do_reset();
        req_din = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111; a0 = ack_cnt; b = rx_n;
        wait_acks(a0 + 4, 400); wait_idle(200);
        chk("t2_acks", 32'(ack_cnt - a0), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_order", 32'(rx_log[(b + i) % 256]), 32'(8'h11 * (i + 1)));

        // two requesters held continuously alternate
        do_reset();
        drop = 0; req_din = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; g0 = gr_n; a0 = ack_cnt;
        req = 4'b0101;
        wait_acks(a0 + 8, 800);
        req = '0; drop = 1;
        wait_idle(200);
        chk("t3_frames", 32'(gr_n - g0), 32'd8);
        for (int i = 0; i < 8; i++) chk("t3_alt", 32'(gr_log[(g0 + i) % 256]), 32'((i % 2) * 2));

        // transmitter never goes busy: timeout abort
        tx_en = 0; a0 = ack_cnt; e0 = err_cnt;
        req_din[15:8] = 8'h3C; req = 4'b0010;
        @(posedge clk); #1;
        chk("t4_send", 32'(o_tx_send), 32'd1);
        t0 = cyc; b = 100;
        while (!o_err && b > 0) begin step(); b--; end
        chk("t4_err_lat", 32'(cyc - t0), 32'd16);
        req = '0;
        chk("t4_send_lo", 32'(o_tx_send), 32'd0);
        chk("t4_busy_lo", 32'(o_busy),    32'd0);
        chk("t4_no_ack",  32'(ack_cnt - a0), 32'd0);
        chk("t4_errs",    32'(err_cnt - e0), 32'd1);
        tx_en = 1; g0 = gr_n; a0 = ack_cnt; req = 4'b1111;
        wait_acks(a0 + 4, 400); wait_idle(200);
        chk("t4_ptr", 32'(gr_log[g0 % 256]), 32'd2);

        // reset in the middle of a frame
        req_din[7:0] = 8'h77; req = 4'b0001; b = 200;
        while (!tx_busy && b > 0) begin step(); b--; end
        repeat (12) step();
        a0 = ack_cnt; e0 = err_cnt;
        rst = 1'b1;
        step();
        chk("t5_send",  32'(o_tx_send), 32'd0);
        chk("t5_grant", 32'(o_grant),   32'd0);
        chk("t5_busy",  32'(o_busy),    32'd0);
        step(); rst = 1'b0;
        repeat (3) step();
        chk("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
        chk("t5_no_err", 32'(err_cnt - e0), 32'd0);
        req_din[23:16] = 8'hA5; req = 4'b0100; a0 = ack_cnt;
        wait_acks(a0 + 1, 200); wait_idle(200);
        chk("t5_rx", 32'(last_rx()), 32'hA5);

        // random traffic, no starvation
        a0 = ack_cnt; rnd = 1;
        wait_acks(a0 + 20, 3000);
        rnd = 0;
        wait_idle(1000);
        chk("t6_idle", 32'(req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
